// File: rtl/phy_rx_sync_pkg.sv
// Shared constants, state encoding and packer request type for the PHY receive front end.
package phy_rx_sync_pkg;

    localparam logic [7:0] COM_SYM     = 8'hBC;
    localparam int         COM_CNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_HUNT   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_ACTIVE = 2'd2
    } rx_state_e;

    // One aligned byte handed from the framer to the word packer.
    typedef struct packed {
        logic       stb;
        logic       clr;
        logic [7:0] data;
    } rx_byte_t;

endpackage

// File: rtl/rx_word_packer.sv
// Packs aligned data bytes MSB-slot-first into 32-bit words; an idle byte drops any partial word.
module rx_word_packer
    import phy_rx_sync_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  rx_byte_t    byte_i,
    output logic [31:0] data_o,
    output logic        valid_o
);

    logic [1:0]  idx_q,   idx_d;
    logic [23:0] word_q,  word_d;
    logic [31:0] data_q,  data_d;
    logic        valid_q, valid_d;

    always_comb begin
        idx_d   = idx_q;
        word_d  = word_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (byte_i.clr) begin
            idx_d = 2'd0;
        end else if (byte_i.stb) begin
            case (idx_q)
                2'd0: word_d[23:16] = byte_i.data;
                2'd1: word_d[15:8]  = byte_i.data;
                2'd2: word_d[7:0]   = byte_i.data;
                default: begin
                    data_d  = {word_q, byte_i.data};
                    valid_d = 1'b1;
                end
            endcase
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q   <= 2'd0;
            word_q  <= 24'd0;
            data_q  <= 32'd0;
            valid_q <= 1'b0;
        end else begin
            idx_q   <= idx_d;
            word_q  <= word_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/phy_rx_sync.sv
// Serial receive framer: hunts for COM byte alignment, locks after COM_COUNT aligned COMs, then packs data.
module phy_rx_sync
    import phy_rx_sync_pkg::*;
#(
    parameter logic [7:0] COM_SYMBOL = COM_SYM,
    parameter int         COM_COUNT  = COM_CNT_DEF
) (
    input  logic        clk_32f,
    input  logic        reset,
    input  logic        serial_in,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        active
);

    rx_state_e  state_q,   state_d;
    logic [7:0] sr_q;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic       active_q,  active_d;
    logic [7:0] cand;
    logic       is_com, boundary;
    rx_byte_t   pk_byte;

    assign cand     = {sr_q[6:0], serial_in};
    assign is_com   = (cand == COM_SYMBOL);
    assign boundary = (bit_cnt_q == 3'd7);

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        active_d  = active_q;
        case (state_q)
            // Bit-granular search; the matching edge becomes the byte phase reference.
            ST_HUNT: begin
                if (is_com) begin
                    bit_cnt_d = 3'd0;
                    com_cnt_d = 4'd1;
                    state_d   = ST_ALIGN;
                end
            end
            ST_ALIGN: begin
                if (boundary) begin
                    if (is_com) begin
                        com_cnt_d = com_cnt_q + 4'd1;
                        if (com_cnt_d == 4'(COM_COUNT)) begin
                            state_d  = ST_ACTIVE;
                            active_d = 1'b1;
                        end
                    end else begin
                        com_cnt_d = 4'd0;
                        state_d   = ST_HUNT;
                    end
                end
            end
            ST_ACTIVE: ;
            default: state_d = ST_HUNT;
        endcase
    end

    always_ff @(posedge clk_32f or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_HUNT;
            sr_q      <= 8'd0;
            bit_cnt_q <= 3'd0;
            com_cnt_q <= 4'd0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= cand;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        pk_byte.data = cand;
        pk_byte.stb  = (state_q == ST_ACTIVE) && boundary && !is_com;
        pk_byte.clr  = (state_q == ST_ACTIVE) && boundary && is_com;
    end

    rx_word_packer u_packer (
        .clk_i   (clk_32f),
        .rst_ni  (reset),
        .byte_i  (pk_byte),
        .data_o  (data_out),
        .valid_o (valid_out)
    );

    assign active = active_q;

endmodule
